// File: rtl/obi_sram_slave.sv
// obi_sram_slave: OBI responder backed by a word-addressed SRAM array.
// Grants after WAIT_CYCLES cycles of held req_i and writes with per-byte enables.
// Read data and rvalid_o are registered and appear one cycle after the grant.
// Optional feature macro: OBI_SRAM_SLAVE_ERR_EN adds err_o and out-of-range detection.
// When the macro is absent, the upper address bits are ignored and the index wraps.
module obi_sram_slave #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned ADDR_BITS   = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
`ifdef OBI_SRAM_SLAVE_ERR_EN
  ,
  output logic        err_o
`endif
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_nxt;
  logic                 w_gnt;
  logic                 w_accept;
  logic                 w_oob;
  logic                 w_wr_en;
  logic [ADDR_BITS-1:0] w_idx;
  logic [31:0]          r_mem [DEPTH];
  logic [31:0]          r_rdata;
  logic                 r_rvalid;
  logic                 w_unused_addr;

  assign w_idx = addr_i[ADDR_BITS+1:2];

`ifdef OBI_SRAM_SLAVE_ERR_EN
  assign w_oob         = ({2'b00, addr_i[31:2]} >= 32'(DEPTH));
  assign w_unused_addr = ^addr_i[1:0];
`else
  assign w_oob         = 1'b0;
  assign w_unused_addr = ^{addr_i[31:ADDR_BITS+2], addr_i[1:0]};
`endif

  // State register and wait counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: count held request cycles, return to idle on grant or on a dropped request
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if ((WAIT_C != 4'd0) && req_i) begin
          w_cnt_nxt   = 4'd1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!req_i || w_gnt) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt < WAIT_C) begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output logic: combinational grant, held low during reset
  always_comb begin
    w_gnt = 1'b0;
    if (!rst_i) begin
      case (r_state)
        S_IDLE:  w_gnt = (WAIT_C == 4'd0) ? req_i : 1'b0;
        S_WAIT:  w_gnt = req_i && (r_cnt == WAIT_C);
        default: w_gnt = 1'b0;
      endcase
    end
  end

  assign gnt_o    = w_gnt;
  assign w_accept = req_i & w_gnt;
  assign w_wr_en  = w_accept & we_i & ~w_oob;

  // SRAM array: byte-enabled write on an accepted in-range write; contents are not reset
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      for (int unsigned n = 0; n < 4; n++) begin
        if (be_i[n]) begin
          r_mem[w_idx][8*n +: 8] <= wdata_i[8*n +: 8];
        end
      end
    end
  end

  // Response registers: rvalid one cycle after acceptance, rdata holds between responses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_accept;
      if (w_accept) begin
        r_rdata <= (we_i || w_oob) ? '0 : r_mem[w_idx];
      end
    end
  end

  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;

`ifdef OBI_SRAM_SLAVE_ERR_EN
  logic r_err;

  // Address error flag, asserted only in the response cycle of an out-of-range request
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept & w_oob;
    end
  end

  assign err_o = r_err;
`endif

endmodule

// File: tb/tb_obi_sram_slave.sv
// Testbench for obi_sram_slave: two instances (WAIT_CYCLES 0 and 3) driven by
// directed and random requests, with responses checked by a queue-based scoreboard.
module tb_obi_sram_slave;

  localparam int unsigned DEPTH = 1024;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_q = 1'b1;
  logic        req   [2];
  logic        gnt   [2];
  logic        rvalid[2];
  logic        we    [2];
  logic [3:0]  be    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
`ifdef OBI_SRAM_SLAVE_ERR_EN
  logic        err   [2];
`endif

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mem_m  [2][DEPTH];
  logic [31:0] last_rd[2];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  obi_sram_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req[0]),
    .gnt_o   (gnt[0]),
    .rvalid_o(rvalid[0]),
    .we_i    (we[0]),
    .be_i    (be[0]),
    .addr_i  (addr[0]),
    .wdata_i (wdata[0]),
    .rdata_o (rdata[0])
`ifdef OBI_SRAM_SLAVE_ERR_EN
    ,
    .err_o   (err[0])
`endif
  );

  obi_sram_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req[1]),
    .gnt_o   (gnt[1]),
    .rvalid_o(rvalid[1]),
    .we_i    (we[1]),
    .be_i    (be[1]),
    .addr_i  (addr[1]),
    .wdata_i (wdata[1]),
    .rdata_o (rdata[1])
`ifdef OBI_SRAM_SLAVE_ERR_EN
    ,
    .err_o   (err[1])
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Present one request, hold it until granted, then update the reference model.
  // Must be called between a rising edge and the following falling edge.
  task automatic issue(input int d, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] wd);
    int unsigned waited;
    int unsigned idx;
    logic        oob;
    exp_t        e;
    waited   = 0;
    req[d]   = 1'b1;
    we[d]    = w;
    be[d]    = b;
    addr[d]  = a;
    wdata[d] = wd;
    @(negedge clk);
    while (gnt[d] !== 1'b1 && waited < 20) begin
      waited++;
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    chk($sformatf("gnt_latency_d%0d", d), waited, wait_of(d));
    if (gnt[d] === 1'b1) begin
      idx = (a >> 2) % DEPTH;
      oob = 1'b0;
`ifdef OBI_SRAM_SLAVE_ERR_EN
      oob = ((a >> 2) >= DEPTH);
`endif
      e.err = oob;
      e.cyc = cyc + 1;
      if (w) begin
        e.data = 32'h0;
        if (!oob) begin
          for (int n = 0; n < 4; n++) begin
            if (b[n]) mem_m[d][idx][8*n +: 8] = wd[8*n +: 8];
          end
        end
      end else begin
        e.data = oob ? 32'h0 : mem_m[d][idx];
      end
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(posedge clk);
    #1;
    req[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard side: compare each instance's response against the queued expectation
  task automatic mon(input int d);
    exp_t e;
    logic due;
    due = 1'b0;
    if (d == 0) begin
      if (q0.size() > 0 && q0[0].cyc == cyc) begin e = q0.pop_front(); due = 1'b1; end
    end else begin
      if (q1.size() > 0 && q1[0].cyc == cyc) begin e = q1.pop_front(); due = 1'b1; end
    end
    if (rst_q) begin
      due        = 1'b0;
      last_rd[d] = 32'h0;
    end
    chk($sformatf("rvalid_d%0d", d), {31'b0, rvalid[d]}, {31'b0, due});
    if (due) begin
      chk($sformatf("rdata_d%0d", d), rdata[d], e.data);
      last_rd[d] = e.data;
`ifdef OBI_SRAM_SLAVE_ERR_EN
      chk($sformatf("err_resp_d%0d", d), {31'b0, err[d]}, {31'b0, e.err});
`endif
    end else begin
      chk($sformatf("rdata_hold_d%0d", d), rdata[d], last_rd[d]);
`ifdef OBI_SRAM_SLAVE_ERR_EN
      chk($sformatf("err_idle_d%0d", d), {31'b0, err[d]}, 32'h0);
`endif
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic directed0();
    issue(0, 1'b1, 4'hF, 32'h10, 32'hA5A5_1234);
    issue(0, 1'b0, 4'hF, 32'h10, 32'h0);
    issue(0, 1'b1, 4'hF, 32'hC, 32'hFFFF_FFFF);
    issue(0, 1'b1, 4'h5, 32'hC, 32'h0000_0000);
    issue(0, 1'b0, 4'h0, 32'hC, 32'h0);
    issue(0, 1'b1, 4'h0, 32'h14, 32'h1234_5678);
    for (int i = 0; i < 8; i++) issue(0, 1'b0, 4'hF, 32'(i * 4), 32'h0);
    idle(1);
    issue(0, 1'b1, 4'hF, 32'h1000, 32'hCAFE_0000);
    issue(0, 1'b0, 4'hF, 32'h0, 32'h0);
  endtask

  task automatic directed1();
    issue(1, 1'b1, 4'hF, 32'h8, 32'h1234_5678);
    issue(1, 1'b0, 4'hF, 32'h8, 32'h0);
    // Request dropped before its grant: no grant, no write
    req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; addr[1] = 32'h1C; wdata[1] = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("gnt_before_drop", {31'b0, gnt[1]}, 32'h0);
      @(posedge clk);
      #1;
    end
    req[1] = 1'b0;
    @(negedge clk);
    chk("gnt_after_drop", {31'b0, gnt[1]}, 32'h0);
    @(posedge clk);
    #1;
    issue(1, 1'b0, 4'hF, 32'h1C, 32'h0);
    for (int i = 0; i < 4; i++) issue(1, 1'b0, 4'hF, 32'(i * 4), 32'h0);
  endtask

  task automatic rand_run(input int d, input int n);
    int unsigned up;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      up = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 32'hFFFFF) : 0;
      a  = (up << 12) | ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
      issue(d, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; be[d] = '0; addr[d] = '0; wdata[d] = '0;
      last_rd[d] = 32'h0;
    end
    // Grant must stay low while reset is asserted, even with a request present
    req[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("gnt_in_reset", {31'b0, gnt[0]}, 32'h0);
    req[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    fork
      for (int i = 0; i < 32; i++) issue(0, 1'b1, 4'hF, 32'(i * 4), $urandom);
      for (int i = 0; i < 32; i++) issue(1, 1'b1, 4'hF, 32'(i * 4), $urandom);
    join
    fork
      directed0();
      directed1();
    join
    idle(2);

    // Reset asserted in the grant cycle of a write: write and response are dropped
    issue(0, 1'b1, 4'hF, 32'h14, 32'h0);
    idle(1);
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h14; wdata[0] = 32'h1111_1111;
    rst = 1'b1;
    @(negedge clk);
    chk("gnt_reset_write", {31'b0, gnt[0]}, 32'h0);
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    rst    = 1'b0;
    idle(1);
    issue(0, 1'b0, 4'hF, 32'h14, 32'h0);
    idle(1);

    fork
      rand_run(0, 300);
      rand_run(1, 150);
    join
    idle(4);
    @(negedge clk);
    chk("q0_drained", q0.size(), 32'h0);
    chk("q1_drained", q1.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
